text_buffer: RTL and testbench
==============================

Name: text_buffer

Overview:
- Writable character buffer that replaces the static text ROM in the serial-LCD text path.
- Accepts a stream of character codes, e.g. from a UART receiver, through a valid/ready handshake.
- Maintains a cursor, interprets a small set of control codes, and stores characters into a tile-addressed RAM.
- Serves the tile-number read port that the font ROM / colour lookup stage consumes.

Parameters:
- TEXT_COLS, 20, characters per row
- TEXT_ROWS, 6, character rows
- ADDR_BITS, 8, read-address width; must cover the tile_num range including the bottom half-line
- CHAR_BITS, 8, character code width
- BLANK_CHAR, 8'h20, fill code used by clear, scroll and out-of-range reads

Ports:
- in_clk  in  1  main clock
- in_rst  in  1  synchronous, active-high reset
- in_char  in  CHAR_BITS  character code to write
- in_char_valid  in  1  in_char is valid
- out_char_ready  out  1  buffer can accept a character this cycle
- in_rd_addr  in  ADDR_BITS  display read address (tile number)
- out_rd_data  out  CHAR_BITS  character at in_rd_addr, registered
- out_cursor_x  out  $clog2(TEXT_COLS)  cursor column
- out_cursor_y  out  $clog2(TEXT_ROWS)  cursor row
- out_busy  out  1  clear or scroll sequence in progress

Behaviour:
- One clock domain (in_clk); reset is synchronous and active-high on in_rst.
- Reset values:
  - cursor = (0,0), out_char_ready = 0, out_busy = 1, out_rd_data = BLANK_CHAR
  - FSM enters CLEAR
- in_rst is honoured in any state; an in-progress clear or scroll is aborted and CLEAR restarts from address 0.
- FSM states: CLEAR, IDLE, SCROLL_RD, SCROLL_WR, SCROLL_BLANK.
- CLEAR:
  - writes BLANK_CHAR to addresses 0..TEXT_ROWS*TEXT_COLS-1, one per cycle (120 cycles at default)
  - then goes to IDLE with ready=1, busy=0
- IDLE: ready=1; a handshake occurs on a rising edge with valid && ready. The accepted character is handled as follows:
  - 0x20..0x7E: written at cursor_y*TEXT_COLS + cursor_x in the same edge; cursor_x++ visible next cycle. At cursor_x = TEXT_COLS-1, a line advance follows instead.
  - 0x0A (LF): line advance.
  - 0x0D (CR): cursor_x = 0.
  - 0x08 (BS): if cursor_x > 0, cursor_x-- and BLANK_CHAR is written at the new position; at cursor_x = 0 there is no effect (no reverse line wrap).
  - 0x0C (FF): cursor = (0,0), enter CLEAR (ready drops the next cycle).
  - Any other code is consumed with no effect.
- Line advance:
  - cursor_x = 0
  - if cursor_y < TEXT_ROWS-1, then cursor_y++
  - otherwise, end-of-screen behaviour applies (see Optional Feature)
- Read port:
  - out_rd_data is registered, with 1-cycle latency from in_rd_addr.
  - Addresses >= TEXT_ROWS*TEXT_COLS return BLANK_CHAR.
  - Display reads during CLEAR or SCROLL return intermediate contents; this is accepted.
- Address arithmetic:
  - computed at ADDR_BITS width
  - row base = cursor_y*TEXT_COLS; no truncation for the given parameter ranges

Optional Feature:
- Macro: TEXT_BUFFER_SCROLL_EN.
- Defined: a line advance from the last row enters the scroll sequence, with ready=0 and busy=1:
  - SCROLL_RD/SCROLL_WR copy word addr+TEXT_COLS to addr for addr = 0..(TEXT_ROWS-1)*TEXT_COLS-1, at 2 cycles per word
  - SCROLL_BLANK writes BLANK_CHAR over the last row, 1 cycle per word
  - total 2*(TEXT_ROWS-1)*TEXT_COLS + TEXT_COLS cycles (220 at default), then IDLE
  - cursor ends at (0, TEXT_ROWS-1)
- Undefined: a line advance from the last row wraps the cursor to (0,0). Content is kept and overwritten in place, and ready stays 1.

Decomposition:
- Shared package text_buffer_pkg holds:
  - the FSM state enum
  - control-code constants (CHR_BS, CHR_LF, CHR_FF, CHR_CR)
  - the printable-range bounds
- Sub-module text_buffer_mem:
  - inferred RAM with one write port and two registered read ports
  - one read port for the display, one for the scroll copy

Test Plan:
- Release reset -> ready=0 for 120 cycles, then ready=1. Reading addresses 0..119 returns 0x20.
- Send "A","B" -> addr0=0x41, addr1=0x42, cursor=(2,0). Each read returns its data 1 cycle after the address.
- Send 21 printable characters -> the 21st lands at addr 20, cursor=(1,1). Then BS twice -> cursor=(0,1), addr20=0x20, and the second BS leaves the cursor unchanged.
- Fill to row 5 and send LF:
  - without the macro -> cursor=(0,0), ready stays 1
  - with the macro -> ready=0 for 220 cycles, old row1 appears in row0, row5 is all 0x20, cursor=(0,5)
- Send FF mid-screen -> 120-cycle clear and cursor=(0,0). Asserting in_rst 50 cycles into a scroll -> CLEAR restarts and all cells end as 0x20.
- Read in_rd_addr 120..255 -> 0x20. Hold valid high with a character while ready=0 -> the character is accepted only after ready returns.

Source files
------------

// File: rtl/text_buffer_pkg.sv
// Shared types and constants for the writable character buffer:
// FSM state encoding, control codes and the printable range.
package text_buffer_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_SCROLL_BLANK
    } state_e;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

endpackage

// File: rtl/text_buffer_mem.sv
// Character RAM: one write port, two registered read ports (display and scroll copy).
// Reads have 1-cycle latency; out-of-range addresses read as BLANK_CHAR, out-of-range writes are dropped.
module text_buffer_mem
    import text_buffer_pkg::*;
#(
    parameter int                   DEPTH      = 120,
    parameter int                   ADDR_BITS  = 8,
    parameter int                   CHAR_BITS  = 8,
    parameter logic [CHAR_BITS-1:0] BLANK_CHAR = 8'h20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [CHAR_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] a_addr_i,
    output logic [CHAR_BITS-1:0] a_data_o,
    input  logic [ADDR_BITS-1:0] b_addr_i,
    output logic [CHAR_BITS-1:0] b_data_o
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(DEPTH);

    logic [CHAR_BITS-1:0] mem_q [DEPTH];
    logic [CHAR_BITS-1:0] a_data_q;
    logic [CHAR_BITS-1:0] b_data_q;

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < DEPTH_A)) begin
            mem_q[waddr_i[MEM_AW-1:0]] <= wdata_i;
        end
    end

    // The display port resets to blank so the first read after reset is defined.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_data_q <= BLANK_CHAR;
        end else if (a_addr_i < DEPTH_A) begin
            a_data_q <= mem_q[a_addr_i[MEM_AW-1:0]];
        end else begin
            a_data_q <= BLANK_CHAR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (b_addr_i < DEPTH_A) begin
            b_data_q <= mem_q[b_addr_i[MEM_AW-1:0]];
        end else begin
            b_data_q <= BLANK_CHAR;
        end
    end

    assign a_data_o = a_data_q;
    assign b_data_o = b_data_q;

endmodule

// File: rtl/text_buffer.sv
// Writable text buffer: cursor + control-code handling over a tile RAM; reads are 1-cycle registered.
// out_char_ready drops during clear/scroll; TEXT_BUFFER_SCROLL_EN selects scroll instead of wrap at screen end.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int                   TEXT_COLS  = 20,
    parameter int                   TEXT_ROWS  = 6,
    parameter int                   ADDR_BITS  = 8,
    parameter int                   CHAR_BITS  = 8,
    parameter logic [CHAR_BITS-1:0] BLANK_CHAR = 8'h20
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic [CHAR_BITS-1:0]         in_char,
    input  logic                         in_char_valid,
    output logic                         out_char_ready,
    input  logic [ADDR_BITS-1:0]         in_rd_addr,
    output logic [CHAR_BITS-1:0]         out_rd_data,
    output logic [$clog2(TEXT_COLS)-1:0] out_cursor_x,
    output logic [$clog2(TEXT_ROWS)-1:0] out_cursor_y,
    output logic                         out_busy
);

    localparam int CX_W       = $clog2(TEXT_COLS);
    localparam int CY_W       = $clog2(TEXT_ROWS);
    localparam int CELLS      = TEXT_ROWS * TEXT_COLS;
    localparam int COPY_CELLS = (TEXT_ROWS - 1) * TEXT_COLS;

    localparam logic [ADDR_BITS-1:0] LAST_A      = ADDR_BITS'(CELLS - 1);
    localparam logic [ADDR_BITS-1:0] COPY_LAST_A = ADDR_BITS'(COPY_CELLS - 1);
    localparam logic [ADDR_BITS-1:0] COLS_A      = ADDR_BITS'(TEXT_COLS);
    localparam logic [CX_W-1:0]      LAST_COL    = CX_W'(TEXT_COLS - 1);
    localparam logic [CY_W-1:0]      LAST_ROW    = CY_W'(TEXT_ROWS - 1);

    state_e               state_q;
    logic [ADDR_BITS-1:0] cnt_q;
    logic [CX_W-1:0]      cx_q;
    logic [CY_W-1:0]      cy_q;
    logic                 ready_q;
    logic                 busy_q;

    logic                 hs;
    logic                 is_print, is_lf, is_cr, is_bs, is_ff;
    logic                 at_eol, at_last_row;
    logic [ADDR_BITS-1:0] cur_addr;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [CHAR_BITS-1:0] mem_wdata;
    logic [ADDR_BITS-1:0] scr_raddr;
    logic [CHAR_BITS-1:0] scr_rdata;

    assign hs          = in_char_valid && ready_q;
    assign is_print    = (in_char >= CHAR_BITS'(CHR_PRINT_LO)) && (in_char <= CHAR_BITS'(CHR_PRINT_HI));
    assign is_lf       = (in_char == CHAR_BITS'(CHR_LF));
    assign is_cr       = (in_char == CHAR_BITS'(CHR_CR));
    assign is_bs       = (in_char == CHAR_BITS'(CHR_BS));
    assign is_ff       = (in_char == CHAR_BITS'(CHR_FF));
    assign at_eol      = (cx_q == LAST_COL);
    assign at_last_row = (cy_q == LAST_ROW);
    assign cur_addr    = ADDR_BITS'(cy_q) * COLS_A + ADDR_BITS'(cx_q);
    // The scroll copy reads one row ahead of the word it is rewriting.
    assign scr_raddr   = cnt_q + COLS_A;

    // Write port: character writes land on the handshake edge itself.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = BLANK_CHAR;
        case (state_q)
            ST_CLEAR, ST_SCROLL_BLANK: begin
                mem_we = 1'b1;
            end
            ST_SCROLL_WR: begin
                mem_we    = 1'b1;
                mem_wdata = scr_rdata;
            end
            ST_IDLE: begin
                if (hs && is_print) begin
                    mem_we    = 1'b1;
                    mem_waddr = cur_addr;
                    mem_wdata = in_char;
                end else if (hs && is_bs && (cx_q != '0)) begin
                    mem_we    = 1'b1;
                    mem_waddr = cur_addr - ADDR_BITS'(1);
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == LAST_A) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_BITS'(1);
                    end
                end
                ST_IDLE: begin
                    if (hs) begin
                        if (is_print && !at_eol) begin
                            cx_q <= cx_q + CX_W'(1);
                        end else if (is_print || is_lf) begin
                            cx_q <= '0;
                            if (!at_last_row) begin
                                cy_q <= cy_q + CY_W'(1);
                            end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
                                state_q <= (TEXT_ROWS > 1) ? ST_SCROLL_RD : ST_SCROLL_BLANK;
                                cnt_q   <= '0;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
`else
                                cy_q <= '0;
`endif
                            end
                        end else if (is_cr) begin
                            cx_q <= '0;
                        end else if (is_bs) begin
                            if (cx_q != '0) begin
                                cx_q <= cx_q - CX_W'(1);
                            end
                        end else if (is_ff) begin
                            state_q <= ST_CLEAR;
                            cnt_q   <= '0;
                            cx_q    <= '0;
                            cy_q    <= '0;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SCROLL_RD: begin
                    state_q <= ST_SCROLL_WR;
                end
                ST_SCROLL_WR: begin
                    cnt_q   <= cnt_q + ADDR_BITS'(1);
                    state_q <= (cnt_q == COPY_LAST_A) ? ST_SCROLL_BLANK : ST_SCROLL_RD;
                end
                ST_SCROLL_BLANK: begin
                    if (cnt_q == LAST_A) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_BITS'(1);
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    text_buffer_mem #(
        .DEPTH      (CELLS),
        .ADDR_BITS  (ADDR_BITS),
        .CHAR_BITS  (CHAR_BITS),
        .BLANK_CHAR (BLANK_CHAR)
    ) u_mem (
        .clk_i    (in_clk),
        .rst_i    (in_rst),
        .we_i     (mem_we),
        .waddr_i  (mem_waddr),
        .wdata_i  (mem_wdata),
        .a_addr_i (in_rd_addr),
        .a_data_o (out_rd_data),
        .b_addr_i (scr_raddr),
        .b_data_o (scr_rdata)
    );

    assign out_char_ready = ready_q;
    assign out_busy       = busy_q;
    assign out_cursor_x   = cx_q;
    assign out_cursor_y   = cy_q;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: vector table, corner sequences, random stream vs. array model.
module tb_text_buffer;

    localparam int C = 20;
    localparam int R = 6;
    localparam int N = C * R;
    localparam logic [7:0] BLANK = 8'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ch;
    logic       vld;
    logic       rdy;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cx;
    logic [2:0] cy;
    logic       busy;

    always #5 clk = ~clk;

    text_buffer dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_char        (ch),
        .in_char_valid  (vld),
        .out_char_ready (rdy),
        .in_rd_addr     (rd_addr),
        .out_rd_data    (rd_data),
        .out_cursor_x   (cx),
        .out_cursor_y   (cy),
        .out_busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_mem [N];
    int mx, my;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = BLANK;
        mx = 0;
        my = 0;
    endtask

    task automatic model_line_adv();
        mx = 0;
        if (my < R - 1) begin
            my++;
        end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
            for (int i = 0; i < N - C; i++) m_mem[i] = m_mem[i + C];
            for (int i = N - C; i < N; i++) m_mem[i] = BLANK;
            my = R - 1;
`else
            my = 0;
`endif
        end
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_mem[my * C + mx] = c;
            if (mx == C - 1) model_line_adv();
            else mx++;
        end else if (c == 8'h0A) begin
            model_line_adv();
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx--;
                m_mem[my * C + mx] = BLANK;
            end
        end else if (c == 8'h0C) begin
            model_reset();
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] c, output int waits);
        ch = c;
        vld = 1'b1;
        waits = 0;
        while (!rdy && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (!rdy) begin
            fail_now("send_ready");
            vld = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            vld = 1'b0;
            model_apply(c);
        end
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!rdy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!rdy) fail_now("wait_ready");
    endtask

    task automatic rd1(input int a, output logic [7:0] d);
        rd_addr = 8'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic check_range(input int lo, input int hi);
        logic [7:0] exp;
        for (int a = lo; a <= hi; a++) begin
            rd_addr = 8'(a);
            @(negedge clk);
            exp = (a < N) ? m_mem[a] : BLANK;
            chk($sformatf("rd[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
        end
    endtask

    task automatic chk_cur(input string name);
        chk({name, "_x"}, {27'd0, cx}, mx);
        chk({name, "_y"}, {29'd0, cy}, my);
    endtask

    typedef struct {
        logic [7:0] c;
        int         ex;
        int         ey;
        int         addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         w;
        int         r;
        logic [7:0] d;
        logic [7:0] c;

        vecs[0]  = '{8'h41, 1, 0, 0,  8'h41};
        vecs[1]  = '{8'h42, 2, 0, 1,  8'h42};
        vecs[2]  = '{8'h0D, 0, 0, 1,  8'h42};
        vecs[3]  = '{8'h43, 1, 0, 0,  8'h43};
        vecs[4]  = '{8'h08, 0, 0, 0,  8'h20};
        vecs[5]  = '{8'h08, 0, 0, 1,  8'h42};
        vecs[6]  = '{8'h0A, 0, 1, 20, 8'h20};
        vecs[7]  = '{8'h01, 0, 1, 20, 8'h20};
        vecs[8]  = '{8'h7F, 0, 1, 20, 8'h20};
        vecs[9]  = '{8'h7E, 1, 1, 20, 8'h7E};
        vecs[10] = '{8'h20, 2, 1, 21, 8'h20};
        vecs[11] = '{8'h7A, 3, 1, 22, 8'h7A};

        rst = 1'b1;
        vld = 1'b0;
        ch = 8'h00;
        rd_addr = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, rdy}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_cx", {27'd0, cx}, 0);
        chk("rst_cy", {29'd0, cy}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'h20);

        rst = 1'b0;
        model_reset();
        wait_ready(w);
        chk("clear_cycles", w, 120);
        chk("idle_busy", {31'd0, busy}, 0);
        check_range(0, N - 1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].c, w);
            chk($sformatf("vec%0d_x", i), {27'd0, cx}, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), {29'd0, cy}, vecs[i].ey);
            rd1(vecs[i].addr, d);
            chk($sformatf("vec%0d_data", i), {24'd0, d}, {24'd0, vecs[i].data});
        end

        // Read latency: data follows the address by exactly one edge.
        rd_addr = 8'd0;
        @(negedge clk);
        chk("lat_a0", {24'd0, rd_data}, 32'h20);
        rd_addr = 8'd1;
        #1;
        chk("lat_hold", {24'd0, rd_data}, 32'h20);
        @(negedge clk);
        chk("lat_a1", {24'd0, rd_data}, 32'h42);

        // FF, then hold valid through the clear; then the 21-char wrap and backspaces.
        send(8'h0C, w);
        chk("ff_ready_drop", {31'd0, rdy}, 0);
        chk("ff_busy", {31'd0, busy}, 1);
        chk_cur("ff_cur");
        send(8'h61, w);
        chk("hold_valid_wait", w, 120);
        for (int i = 1; i < 21; i++) send(8'(8'h61 + i), w);
        chk("wrap_x", {27'd0, cx}, 1);
        chk("wrap_y", {29'd0, cy}, 1);
        rd1(20, d);
        chk("wrap_addr20", {24'd0, d}, 32'h75);
        send(8'h08, w);
        chk("bs1_x", {27'd0, cx}, 0);
        chk("bs1_y", {29'd0, cy}, 1);
        rd1(20, d);
        chk("bs1_addr20", {24'd0, d}, 32'h20);
        send(8'h08, w);
        chk("bs2_x", {27'd0, cx}, 0);
        chk("bs2_y", {29'd0, cy}, 1);
        rd1(19, d);
        chk("bs2_addr19", {24'd0, d}, 32'h74);

        // End of screen.
        send(8'h0C, w);
        wait_ready(w);
        for (int i = 0; i < C; i++) send(8'(8'h61 + i), w);
        for (int i = 0; i < C; i++) send(8'(8'h41 + i), w);
        repeat (3) send(8'h0A, w);
        send(8'h58, w);
        chk("eos_pre_y", {29'd0, cy}, 5);
        send(8'h0A, w);
`ifdef TEXT_BUFFER_SCROLL_EN
        chk("scroll_ready_drop", {31'd0, rdy}, 0);
        chk("scroll_busy", {31'd0, busy}, 1);
        wait_ready(w);
        chk("scroll_cycles", w, 220);
        chk("scroll_x", {27'd0, cx}, 0);
        chk("scroll_y", {29'd0, cy}, 5);
        for (int i = 0; i < C; i++) begin
            rd1(i, d);
            chk($sformatf("scroll_row0[%0d]", i), {24'd0, d}, 32'(8'h41 + i));
            rd1(N - C + i, d);
            chk($sformatf("scroll_row5[%0d]", i), {24'd0, d}, 32'h20);
        end
        rd1(80, d);
        chk("scroll_row4_x", {24'd0, d}, 32'h58);
`else
        chk("wrap_ready_stays", {31'd0, rdy}, 1);
        chk("wrap_eos_x", {27'd0, cx}, 0);
        chk("wrap_eos_y", {29'd0, cy}, 0);
        rd1(0, d);
        chk("wrap_keep0", {24'd0, d}, 32'h61);
        rd1(100, d);
        chk("wrap_keep100", {24'd0, d}, 32'h58);
`endif
        check_range(0, N - 1);

        // Reset in the middle of a long sequence.
`ifdef TEXT_BUFFER_SCROLL_EN
        send(8'h0A, w);
`else
        send(8'h0C, w);
`endif
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, rdy}, 0);
        rst = 1'b0;
        model_reset();
        wait_ready(w);
        chk("midrst_clear_cycles", w, 120);
        chk_cur("midrst_cur");
        check_range(0, N - 1);
        check_range(N, 255);

        // Random stream against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      c = 8'($urandom_range(32, 126));
            else if (r < 80) c = 8'h0A;
            else if (r < 85) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else if (r < 93) c = 8'h0C;
            else             c = 8'($urandom_range(0, 255));
            send(c, w);
            if (!rdy) wait_ready(w);
            chk_cur($sformatf("rnd%0d", i));
            if (i % 100 == 99) check_range(0, N - 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
